pipe_stage_skid: RTL and testbench
==================================

// Module: pipe_stage_skid
// PURPOSE
//  Parametrised inter-stage pipeline register (EXE->MEM and later stages) for the vector datapath.
//  - Carries CTRL_W write-enable bits plus LANES data words of DATA_W bits.
//  - Adds valid/ready backpressure through a 2-entry skid buffer, plus synchronous flush.
//  - Provides a saturating stall-cycle counter.
//  - Full throughput (1 beat/cycle), 1-cycle latency; in_ready comes straight from a flop.
// PARAMETERS
//  DATA_W  32  width of one data lane (i, j, n, addr, r1..r4 style words)
//  LANES   8   number of data lanes carried per beat
//  CTRL_W  5   number of control/write-enable bits carried per beat
//  CNT_W   16  width of stall counter
// PORTS
//  clk        in   1             clock, rising edge
//  rst        in   1             reset: asynchronous, active-high
//  flush      in   1             synchronous kill of all held beats
//  in_valid   in   1             upstream beat present
//  in_ready   out  1             stage can accept a beat this cycle
//  in_ctrl    in   CTRL_W        upstream control bits
//  in_data    in   LANES*DATA_W  upstream lanes; lane k = bits [k*DATA_W +: DATA_W]
//  out_valid  out  1             beat presented downstream
//  out_ready  in   1             downstream accepts beat
//  out_ctrl   out  CTRL_W        control bits; forced 0 when out_valid=0
//  out_data   out  LANES*DATA_W  data lanes of presented beat
//  stall_cnt  out  CNT_W         cycles with out_valid=1 and out_ready=0, saturating
// BEHAVIOUR
//  Storage and reset
//  - Two registers: MAIN (drives outputs) and SKID; each holds valid, ctrl and data.
//  - While rst=1, asynchronously: both valids=0, all ctrl/data=0, stall_cnt=0.
//  - Consequently out_valid=0, out_ctrl=0, out_data=0 and in_ready=1 after reset.
//  Handshake
//  - in_ready = !SKID.valid (registered; no combinational path from out_ready).
//  - acc_in  = in_valid & in_ready.
//  - acc_out = out_valid & out_ready.
//  - Upstream must hold in_valid/in_ctrl/in_data stable until accepted.
//  Per clock edge (flush=0)
//  - If !MAIN.valid | acc_out: MAIN <= SKID if SKID.valid, else the input beat. MAIN.valid <= SKID.valid | acc_in.
//  - Else, if acc_in: SKID <= input beat, SKID.valid <= 1.
//  - SKID.valid clears when SKID moves to MAIN.
//  - Ordering is strictly FIFO: a SKID beat always leaves before any newer beat.
//  - Simultaneous acc_in & acc_out with SKID empty: the input goes straight to MAIN (pass-through, no bubble).
//  - Occupancy never exceeds 2; in_ready=0 exactly when both entries are full.
//  Flush
//  - flush=1 at an edge: MAIN.valid <= 0 and SKID.valid <= 0.
//  - A beat accepted in the same cycle is dropped; flush has priority over everything.
//  - Data registers may keep stale values, but out_ctrl reads 0 immediately after, because valid=0.
//  Outputs and counter
//  - out_ctrl = MAIN.valid ? MAIN.ctrl : 0, so a bubble never raises a write enable.
//  - out_data = MAIN.data, unmasked.
//  - stall_cnt increments when out_valid & !out_ready, holds at 2^CNT_W-1, and is cleared only by rst.
// TESTING
//  1. Stream 10 beats, out_ready=1 always -> each beat appears 1 cycle after acceptance, in order; in_ready stays 1; stall_cnt=0.
//  2. Beats A,B,C with out_ready=0 from cycle 1 -> A in MAIN, B in SKID, in_ready=0, C held; set out_ready=1 -> A,B,C emerge consecutively; stall_cnt = stalled cycles.
//  3. flush while 2 beats held and in_valid=1 -> next cycle out_valid=0, out_ctrl=0, in_ready=1; the held beats and the incoming beat never appear.
//  4. Assert rst mid-stream asynchronously (between edges) -> out_valid, out_ctrl, out_data, stall_cnt go 0 immediately; after release in_ready=1.
//  5. CNT_W=4, hold a stall for 20 cycles -> stall_cnt reaches 15 and stays there.
//  6. Random in_valid/out_ready (LANES=4, DATA_W=16) vs. scoreboard FIFO -> no loss, no duplication, no reordering; out_ctrl=0 whenever out_valid=0.

Source files
------------

// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: inter-stage register with a 2-entry skid buffer, synchronous flush and a saturating stall counter.
// in_ready is taken straight from the SKID valid flop, so out_ready never reaches upstream combinationally.
module pipe_stage_skid #(
    parameter int DATA_W = 32,
    parameter int LANES  = 8,
    parameter int CTRL_W = 5,
    parameter int CNT_W  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [CTRL_W-1:0]       in_ctrl,
    input  logic [LANES*DATA_W-1:0] in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [CTRL_W-1:0]       out_ctrl,
    output logic [LANES*DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]        stall_cnt
);
    localparam int DW = LANES * DATA_W;

    logic              main_v_q, main_v_d, skid_v_q, skid_v_d;
    logic [CTRL_W-1:0] main_c_q, main_c_d, skid_c_q, skid_c_d;
    logic [DW-1:0]     main_dat_q, main_dat_d, skid_dat_q, skid_dat_d;
    logic [CNT_W-1:0]  stall_q, stall_d;
    logic              acc_in, acc_out, load_main, load_skid;

    assign in_ready  = !skid_v_q;
    assign acc_in    = in_valid & in_ready;
    assign acc_out   = main_v_q & out_ready;
    // MAIN refills whenever it is empty or its beat leaves; otherwise a new beat parks in SKID.
    assign load_main = !main_v_q | acc_out;
    assign load_skid = !load_main & acc_in;

    always_comb begin
        main_v_d   = flush ? 1'b0 : (load_main ? (skid_v_q | acc_in) : main_v_q);
        main_c_d   = load_main ? (skid_v_q ? skid_c_q : in_ctrl) : main_c_q;
        main_dat_d = load_main ? (skid_v_q ? skid_dat_q : in_data) : main_dat_q;
        skid_v_d   = flush ? 1'b0 : (load_main ? 1'b0 : (skid_v_q | acc_in));
        skid_c_d   = load_skid ? in_ctrl : skid_c_q;
        skid_dat_d = load_skid ? in_data : skid_dat_q;
        stall_d    = (main_v_q && !out_ready && stall_q != {CNT_W{1'b1}}) ? stall_q + 1'b1 : stall_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_v_q   <= 1'b0;
            main_c_q   <= '0;
            main_dat_q <= '0;
            skid_v_q   <= 1'b0;
            skid_c_q   <= '0;
            skid_dat_q <= '0;
            stall_q    <= '0;
        end else begin
            main_v_q   <= main_v_d;
            main_c_q   <= main_c_d;
            main_dat_q <= main_dat_d;
            skid_v_q   <= skid_v_d;
            skid_c_q   <= skid_c_d;
            skid_dat_q <= skid_dat_d;
            stall_q    <= stall_d;
        end
    end

    assign out_valid = main_v_q;
    assign out_ctrl  = main_v_q ? main_c_q : '0;
    assign out_data  = main_dat_q;
    assign stall_cnt = stall_q;
endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb_pipe_stage_skid: random and directed stimulus against a 2-deep FIFO scoreboard with a saturating stall model.
module tb_pipe_stage_skid;
    localparam int DATA_W = 16, LANES = 4, CTRL_W = 5, CNT_W = 4;
    localparam int DW = DATA_W * LANES;

    typedef struct packed {
        logic [CTRL_W-1:0] c;
        logic [DW-1:0]     d;
    } beat_t;

    logic              clk = 1'b0, rst = 1'b1, flush = 1'b0;
    logic              in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0;
    logic [CTRL_W-1:0] in_ctrl = '0, out_ctrl;
    logic [DW-1:0]     in_data = '0, out_data;
    logic [CNT_W-1:0]  stall_cnt;

    int    checks = 0, errors = 0;
    beat_t q[$];
    int    stall_m = 0;
    bit    consumed = 1'b1;

    pipe_stage_skid #(.DATA_W(DATA_W), .LANES(LANES), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
        .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: the stage behaves as a FIFO of depth 2 that loses everything on flush.
    always @(negedge clk) begin
        if (rst) begin
            q.delete();
            stall_m = 0;
            consumed = 1'b1;
            chk("rst_out_valid", DW'(out_valid), '0);
            chk("rst_in_ready", DW'(in_ready), DW'(1));
            chk("rst_out_ctrl", DW'(out_ctrl), '0);
            chk("rst_stall", DW'(stall_cnt), '0);
        end else begin
            bit acc_in, acc_out;
            chk("out_valid", DW'(out_valid), DW'(q.size() > 0));
            chk("in_ready", DW'(in_ready), DW'(q.size() < 2));
            chk("stall_cnt", DW'(stall_cnt), DW'(stall_m));
            if (q.size() > 0) begin
                chk("out_ctrl", DW'(out_ctrl), DW'(q[0].c));
                chk("out_data", out_data, q[0].d);
            end else
                chk("out_ctrl_bubble", DW'(out_ctrl), '0);
            acc_in  = in_valid && q.size() < 2;
            acc_out = q.size() > 0 && out_ready;
            if (q.size() > 0 && !out_ready && stall_m < 15) stall_m++;
            consumed = acc_in || flush;
            if (flush) q.delete();
            else begin
                if (acc_out) void'(q.pop_front());
                if (acc_in) q.push_back('{c: in_ctrl, d: in_data});
            end
        end
    end

    task automatic step(input bit v, input bit ordy, input bit fl);
        out_ready = ordy;
        flush = fl;
        if (consumed || !in_valid) begin
            in_valid = v;
            in_ctrl = CTRL_W'($urandom);
            in_data = {$urandom, $urandom};
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #23 rst = 1'b0;
        @(posedge clk);
        #1;
        // Streaming at full rate
        for (int i = 0; i < 10; i++) step(1, 1, 0);
        chk("t1_in_ready", DW'(in_ready), DW'(1));
        for (int i = 0; i < 3; i++) step(0, 1, 0);
        chk("t1_stall", DW'(stall_cnt), '0);
        // Backpressure fills MAIN and SKID
        for (int i = 0; i < 3; i++) step(1, 0, 0);
        chk("t2_in_ready_full", DW'(in_ready), '0);
        chk("t2_out_valid", DW'(out_valid), DW'(1));
        for (int i = 0; i < 5; i++) step(0, 1, 0);
        chk("t2_stall", DW'(stall_cnt), DW'(2));
        chk("t2_drained", DW'(out_valid), '0);
        // Flush with both entries held and a beat waiting
        for (int i = 0; i < 3; i++) step(1, 0, 0);
        step(1, 0, 1);
        chk("t3_out_valid", DW'(out_valid), '0);
        chk("t3_out_ctrl", DW'(out_ctrl), '0);
        chk("t3_in_ready", DW'(in_ready), DW'(1));
        for (int i = 0; i < 3; i++) step(0, 1, 0);
        chk("t3_stall", DW'(stall_cnt), DW'(5));
        // Saturating stall counter
        step(1, 0, 0);
        for (int i = 0; i < 20; i++) step(0, 0, 0);
        chk("t5_stall_sat", DW'(stall_cnt), DW'(15));
        // Asynchronous reset mid-stream
        for (int i = 0; i < 4; i++) step(1, 1, 0);
        #2 rst = 1'b1;
        in_valid = 1'b0;
        #1;
        chk("t4_out_valid", DW'(out_valid), '0);
        chk("t4_out_ctrl", DW'(out_ctrl), '0);
        chk("t4_out_data", out_data, '0);
        chk("t4_stall", DW'(stall_cnt), '0);
        @(posedge clk);
        #3 rst = 1'b0;
        chk("t4_in_ready", DW'(in_ready), DW'(1));
        @(posedge clk);
        #1;
        // Random traffic
        for (int i = 0; i < 3000; i++)
            step($urandom_range(3, 0) != 0, $urandom_range(2, 0) != 0, $urandom_range(39, 0) == 0);
        for (int i = 0; i < 4; i++) step(0, 1, 0);
        chk("t6_empty", DW'(out_valid), '0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
